// File: rtl/ioctl_pkg.sv
// Shared types and helpers for the ioctl upload/download SDRAM paths.
package ioctl_pkg;

  localparam int IOCTL_AW = 25;
  localparam int SDRAM_WA = 23;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_HIT    = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  // Picks the addressed byte out of a 16-bit SDRAM word (hi = address bit 0).
  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/toggle_req_port.sv
// Toggle req/ack handshake towards an SDRAM port: request toggle, ack
// synchroniser into clk_sys and a completion pulse.
module toggle_req_port (
  input  logic clk_sys,
  input  logic reset,
  input  logic issue,
  input  logic realign,
  input  logic port_ack,
  output logic port_req,
  output logic done
);

  logic ack_m_q, ack_s_q;
  logic req_q, req_d;
  logic out_q, out_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    req_d = req_q;
    out_d = out_q;
    done  = out_q && (ack_s_q == req_q);
    if (realign) begin
      req_d = ack_s_q;
      out_d = 1'b0;
    end else if (issue) begin
      req_d = ~req_q;
      out_d = 1'b1;
    end else if (done) begin
      out_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ack_m_q <= 1'b0;
      ack_s_q <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      ack_m_q <= port_ack;
      ack_s_q <= ack_m_q;
      out_q   <= out_d;
    end
  end

  // NOTE: req is deliberately not reset; a request may still be in flight in
  // the memory domain, and the owner realigns req to the synchronised ack
  // once it has settled instead of forcing a parity change.
  always_ff @(posedge clk_sys) begin
    req_q <= req_d;
  end

  assign port_req = req_q;

endmodule

// File: rtl/ioctl_upload_rd.sv
// Byte reader for ioctl uploads: fetches 16-bit SDRAM words with a one-word
// cache. Define ACK_TIMEOUT_EN to add the ack watchdog and sticky err flag.
module ioctl_upload_rd
  import ioctl_pkg::*;
#(
  parameter logic [IOCTL_AW-1:0] BASE_ADDR     = 25'h0,
  parameter int                  RESYNC_CYCLES = 8,
  parameter int                  TIMEOUT       = 1023
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_din_valid,
  output logic                busy,
  output logic                port_req,
  input  logic                port_ack,
  output logic [SDRAM_WA-1:0] port_a,
  output logic [1:0]          port_ds,
  output logic                port_we,
  input  logic [15:0]         port_q,
  output logic                err
);

  localparam int RC_W = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESYNC_CYCLES - 1);

  state_e              state_q, state_d;
  logic [RC_W-1:0]     cnt_q, cnt_d;
  logic [15:0]         cache_word_q, cache_word_d;
  logic [SDRAM_WA-1:0] cache_wa_q, cache_wa_d;
  logic                cache_valid_q, cache_valid_d;
  logic [SDRAM_WA-1:0] port_a_q, port_a_d;
  logic [1:0]          port_ds_q, port_ds_d;
  logic [7:0]          din_q, din_d;
  logic                valid_q, valid_d;
  logic                upload_q, upload_d;
  logic                drop_q, drop_d;
  logic                issue, realign, done;

  logic [IOCTL_AW-1:0] eff;
  logic [SDRAM_WA-1:0] eff_wa;
  logic                rd_go, upload_fall, hit;

  assign eff         = ioctl_addr + BASE_ADDR;
  assign eff_wa      = eff[SDRAM_WA:1];
  assign rd_go       = ioctl_rd & ioctl_upload;
  assign upload_fall = upload_q & ~ioctl_upload;
  assign hit         = cache_valid_q && (cache_wa_q == eff_wa);

`ifdef ACK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cache_word_d  = cache_word_q;
    cache_wa_d    = cache_wa_q;
    cache_valid_d = cache_valid_q;
    port_a_d      = port_a_q;
    port_ds_d     = port_ds_q;
    din_d         = din_q;
    valid_d       = 1'b0;
    upload_d      = ioctl_upload;
    drop_d        = drop_q;
    issue         = 1'b0;
    realign       = 1'b0;
`ifdef ACK_TIMEOUT_EN
    wd_d          = wd_q;
    err_d         = err_q;
`endif

    if (upload_fall) cache_valid_d = 1'b0;

    case (state_q)
      ST_RESYNC: begin
        if (cnt_q == RC_LAST) begin
          realign = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + RC_W'(1);
        end
      end
      ST_IDLE: begin
        if (rd_go) begin
          if (hit) begin
            din_d   = byte_sel(cache_word_q, eff[0]);
            valid_d = 1'b1;
            state_d = ST_HIT;
          end else begin
            port_a_d  = eff_wa;
            port_ds_d = {eff[0], ~eff[0]};
            issue     = 1'b1;
            drop_d    = 1'b0;
            state_d   = ST_WAIT;
`ifdef ACK_TIMEOUT_EN
            wd_d      = '0;
`endif
          end
        end
      end
      ST_HIT: state_d = ST_IDLE;
      ST_WAIT: begin
        if (upload_fall) drop_d = 1'b1;
        if (done) begin
          state_d = ST_IDLE;
          // A window closed mid-fetch still consumes the ack but returns nothing.
          if (!drop_q && !upload_fall) begin
            cache_word_d  = port_q;
            cache_wa_d    = port_a_q;
            cache_valid_d = 1'b1;
            din_d         = byte_sel(port_q, port_ds_q[1]);
            valid_d       = 1'b1;
          end
        end
`ifdef ACK_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          din_d         = 8'hFF;
          valid_d       = 1'b1;
          err_d         = 1'b1;
          cache_valid_d = 1'b0;
          cnt_d         = '0;
          state_d       = ST_RESYNC;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= ST_RESYNC;
      cnt_q         <= '0;
      cache_valid_q <= 1'b0;
      port_a_q      <= '0;
      port_ds_q     <= 2'b01;
      din_q         <= 8'h00;
      valid_q       <= 1'b0;
      upload_q      <= 1'b0;
      drop_q        <= 1'b0;
`ifdef ACK_TIMEOUT_EN
      wd_q          <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cache_valid_q <= cache_valid_d;
      port_a_q      <= port_a_d;
      port_ds_q     <= port_ds_d;
      din_q         <= din_d;
      valid_q       <= valid_d;
      upload_q      <= upload_d;
      drop_q        <= drop_d;
`ifdef ACK_TIMEOUT_EN
      wd_q          <= wd_d;
      err_q         <= err_d;
`endif
    end
  end

  // Cached data is qualified by cache_valid_q, so it needs no reset.
  always_ff @(posedge clk_sys) begin
    cache_word_q <= cache_word_d;
    cache_wa_q   <= cache_wa_d;
  end

  toggle_req_port u_port (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .issue    (issue),
    .realign  (realign),
    .port_ack (port_ack),
    .port_req (port_req),
    .done     (done)
  );

  assign ioctl_din       = din_q;
  assign ioctl_din_valid = valid_q;
  assign busy            = (state_q != ST_IDLE);
  assign port_a          = port_a_q;
  assign port_ds         = port_ds_q;
  assign port_we         = 1'b0;

`ifdef ACK_TIMEOUT_EN
  assign err = err_q;
  logic unused_ok;
  assign unused_ok = &{1'b0, eff[IOCTL_AW-1]};
`else
  assign err = 1'b0;
  logic unused_ok;
  assign unused_ok = &{1'b0, eff[IOCTL_AW-1], (TIMEOUT > 0)};
`endif

endmodule

// File: tb/tb_ioctl_upload_rd.sv
// Randomised self-checking bench for ioctl_upload_rd against a word-cache
// reference model and a toggle-handshake SDRAM model.
module tb_ioctl_upload_rd;
  import ioctl_pkg::*;

  localparam logic [24:0] TB_BASE    = 25'h0;
  localparam int          TB_TIMEOUT = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload, ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_din_valid, busy, port_req, port_ack, port_we, err;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_q;

  int n_vec = 0;
  int n_err = 0;

  ioctl_upload_rd #(
    .BASE_ADDR     (TB_BASE),
    .RESYNC_CYCLES (8),
    .TIMEOUT       (TB_TIMEOUT)
  ) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .ioctl_upload    (ioctl_upload),
    .ioctl_rd        (ioctl_rd),
    .ioctl_addr      (ioctl_addr),
    .ioctl_din       (ioctl_din),
    .ioctl_din_valid (ioctl_din_valid),
    .busy            (busy),
    .port_req        (port_req),
    .port_ack        (port_ack),
    .port_a          (port_a),
    .port_ds         (port_ds),
    .port_we         (port_we),
    .port_q          (port_q),
    .err             (err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SDRAM contents: a fixed hash plus the known word from the directed test.
  function automatic logic [15:0] mem_word(input logic [22:0] a);
    if (a == 23'h10) return 16'hBEEF;
    return (a[15:0] * 16'h9E37) ^ 16'h5A3C;
  endfunction

  // SDRAM port model: services any outstanding req != ack after mem_lat cycles.
  int mem_lat = 3;
  bit ack_en  = 1'b1;
  logic [22:0] mem_addr;
  initial begin
    port_ack = 1'b0;
    port_q   = 16'h0;
    forever begin
      @(negedge clk_sys);
      if (ack_en && (port_req === ~port_ack)) begin
        mem_addr = port_a;
        repeat (mem_lat) @(negedge clk_sys);
        port_q   = mem_word(mem_addr);
        port_ack = ~port_ack;
      end
    end
  end

  int   valid_cnt  = 0;
  int   toggle_cnt = 0;
  logic prev_req   = 1'b0;
  always @(negedge clk_sys) begin
    if (ioctl_din_valid === 1'b1) valid_cnt++;
    if (port_req !== prev_req) toggle_cnt++;
    prev_req = port_req;
  end

  // Reference cache: which word the reader currently holds.
  bit          m_valid = 1'b0;
  logic [22:0] m_wa    = '0;

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic do_read(input logic [24:0] addr, input bit extra_rd);
    logic [24:0] eff;
    logic [22:0] wa;
    logic [15:0] word;
    logic [7:0]  exp_b;
    bit          exp_hit, got;
    int          v0, t0, lat;
    eff     = addr + TB_BASE;
    wa      = eff[23:1];
    word    = mem_word(wa);
    exp_b   = eff[0] ? word[15:8] : word[7:0];
    exp_hit = m_valid && (m_wa == wa);
    @(posedge clk_sys); #1;
    v0 = valid_cnt;
    t0 = toggle_cnt;
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    if (!exp_hit) begin
      check("miss_busy", busy, 1'b1);
      check("miss_port_a", port_a, wa);
      check("miss_port_ds", port_ds, {eff[0], ~eff[0]});
      if (extra_rd) begin
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b1;
        ioctl_addr = addr ^ 25'h40;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
      end
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk_sys);
      lat++;
      if (ioctl_din_valid === 1'b1) got = 1'b1;
    end
    check("valid_seen", got, 1'b1);
    check("din", ioctl_din, exp_b);
    if (exp_hit) check("hit_latency", lat, 1);
    repeat (4) @(posedge clk_sys);
    #1;
    check("valid_pulses", valid_cnt - v0, 1);
    check("req_toggles", toggle_cnt - t0, exp_hit ? 0 : 1);
    m_valid = 1'b1;
    m_wa    = wa;
  endtask

  task automatic ignored_read(input logic [24:0] addr);
    int v0, t0;
    @(posedge clk_sys); #1;
    ioctl_upload = 1'b0;
    m_valid      = 1'b0;
    v0 = valid_cnt;
    t0 = toggle_cnt;
    @(posedge clk_sys); #1;
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    check("noup_valid", valid_cnt - v0, 0);
    check("noup_toggle", toggle_cnt - t0, 0);
    ioctl_upload = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, t0;
    reset        = 1'b1;
    ioctl_upload = 1'b1;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_din", ioctl_din, 8'h00);
    check("rst_valid", ioctl_din_valid, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_port_a", port_a, 23'h0);
    check("rst_port_ds", port_ds, 2'b01);
    check("rst_err", err, 1'b0);
    check("rst_we", port_we, 1'b0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    wait_idle("resync_done");
    check("resync_align", port_req, port_ack);

    // Directed: miss, hit, busy read.
    mem_lat = 3;
    do_read(25'h21, 1'b0);
    do_read(25'h20, 1'b0);
    m_valid = 1'b0;
    do_read(25'h1000, 1'b1);

    // Upload window closes mid-fetch: no return, cache dropped.
    mem_lat = 6;
    @(posedge clk_sys); #1;
    v0 = valid_cnt;
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h20;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    @(posedge clk_sys); #1;
    ioctl_upload = 1'b0;
    m_valid      = 1'b0;
    repeat (20) @(posedge clk_sys);
    #1;
    check("drop_valid", valid_cnt - v0, 0);
    check("drop_busy", busy, 1'b0);
    check("drop_align", port_req, port_ack);
    ioctl_upload = 1'b1;
    do_read(25'h20, 1'b0);

    // Reset while a fetch is in flight; the ack lands after reset.
    mem_lat = 4;
    @(posedge clk_sys); #1;
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h101;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    reset   = 1'b0;
    m_valid = 1'b0;
    wait_idle("rst_wait_idle");
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_wait_align", port_req, port_ack);
    t0 = toggle_cnt;
    repeat (10) @(posedge clk_sys);
    #1;
    check("rst_wait_quiet", toggle_cnt - t0, 0);
    do_read(25'h21, 1'b0);

    // Randomised reads over a small window so hits and misses both occur.
    for (int i = 0; i < 40; i++) begin
      logic [24:0] a;
      a = 25'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a[24] = 1'b1;
      mem_lat = $urandom_range(1, 5);
      if ($urandom_range(0, 7) == 0) ignored_read(a);
      else do_read(a, $urandom_range(0, 3) == 0);
    end

`ifdef ACK_TIMEOUT_EN
    begin
      int  lat;
      bit  got;
      ack_en  = 1'b0;
      m_valid = 1'b0;
      @(posedge clk_sys); #1;
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h1FE;
      @(posedge clk_sys); #1;
      ioctl_rd = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 60) begin
        @(negedge clk_sys);
        lat++;
        if (ioctl_din_valid === 1'b1) got = 1'b1;
      end
      check("to_valid", got, 1'b1);
      check("to_latency", lat, TB_TIMEOUT + 1);
      check("to_din", ioctl_din, 8'hFF);
      check("to_err", err, 1'b1);
      wait_idle("to_resync");
      ack_en = 1'b1;
      do_read(25'h21, 1'b0);
      check("to_err_sticky", err, 1'b1);
      @(posedge clk_sys); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      check("to_err_clear", err, 1'b0);
      reset = 1'b0;
      wait_idle("to_final_idle");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ioctl_upload_rd.md
Name: ioctl_upload_rd

Overview:
- Reader counterpart to the ROM download path. Services host byte-read requests during an ioctl upload (e.g. hiscore/NVRAM save) by fetching 16-bit words from an SDRAM port over the toggle req/ack handshake.
- Returns the selected byte to the data_io upload interface.
- Sits in the core top level beside the download controller, on clk_sys, driving a spare sdram port.

Parameters:
- BASE_ADDR, 25'h0, byte offset added to ioctl_addr before the SDRAM access (modulo 2^25).
- RESYNC_CYCLES, 8, idle cycles after reset before port_req is realigned to port_ack.
- TIMEOUT, 1023, ack watchdog limit in clk_sys cycles (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock; all logic is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  upload window active.
- ioctl_rd  in  1  single-cycle byte read strobe.
- ioctl_addr  in  25  byte address of the read.
- ioctl_din  out  8  returned byte; held until the next return.
- ioctl_din_valid  out  1  one-cycle pulse, ioctl_din valid.
- busy  out  1  high while a read is outstanding or during resync.
- port_req  out  1  toggle request to the sdram port.
- port_ack  in  1  toggle ack from the sdram port (clk_mem domain).
- port_a  out  23  SDRAM word address.
- port_ds  out  2  byte enables {eff[0], ~eff[0]}.
- port_we  out  1  tied 0.
- port_q  in  16  read word; stable once the ack toggles.
- err  out  1  sticky timeout flag (ACK_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Clocking/reset: one clock (clk_sys); reset is synchronous, active-high.
- Reset values: ioctl_din=8'h00, ioctl_din_valid=0, busy=1, port_a=0, port_ds=2'b01, err=0, cache invalid, state RESYNC.
- port_ack passes through a 2-flop synchroniser to give ack_s.
- eff = ioctl_addr + BASE_ADDR, 25-bit wrap. port_a = eff[23:1]; eff[24] is ignored.
- Byte select: eff[0]=0 gives q[7:0]; eff[0]=1 gives q[15:8].
- RESYNC: count RESYNC_CYCLES, then port_req <= ack_s and go to IDLE. This realigns parity if a request was in flight at reset.
- IDLE (busy=0): on ioctl_rd & ioctl_upload:
  - Hit (cache valid and eff[23:1] == cached word address): go to HIT. Next cycle drive the byte from the cached word and pulse valid. Latency 1.
  - Miss: latch port_a/port_ds, toggle port_req, go to WAIT.
- ioctl_rd with ioctl_upload=0 is ignored.
- WAIT (busy=1): when ack_s == port_req, latch port_q into the cache, store the word address, set cache valid, drive the byte, pulse valid, go to IDLE. Minimum miss latency is SDRAM latency + 3 cycles.
- ioctl_rd while busy is ignored: no queueing, no second request.
- ioctl_upload falling edge invalidates the cache. If this happens in WAIT, the ack is still awaited to preserve toggle parity, but no valid pulse is issued and nothing is cached.
- Reset during WAIT: the state is abandoned and the RESYNC rule applies.
- Simultaneous ioctl_rd and ioctl_upload falling edge: the read is ignored.

Optional Feature:
- ACK_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT. On reaching TIMEOUT, return 8'hFF with a valid pulse, set err (cleared only by reset), invalidate the cache, and go to RESYNC.
- ACK_TIMEOUT_EN undefined:
  - No counter; WAIT lasts until the ack toggles; err is tied 0.

Decomposition:
- Shared package ioctl_pkg holds:
  - state enum {RESYNC, IDLE, HIT, WAIT};
  - IOCTL_AW=25 and SDRAM_WA=23 width constants;
  - the byte-select function.
- One sub-module, toggle_req_port: req toggle, ack synchroniser, and done pulse. It is reusable by the download controller.

Test Plan:
- Miss read: BASE_ADDR=0, word 0x0010 holds 16'hBEEF, rd at addr 0x21 -> port_req toggles once, port_a=0x10, port_ds=2'b10, ioctl_din=8'hBE, valid pulses exactly once.
- Hit read: rd at addr 0x20 right after the previous case -> no port_req toggle, ioctl_din=8'hEF one cycle after rd.
- Busy rd: a second rd during WAIT -> ignored, one toggle total, one valid pulse.
- Upload drop: ioctl_upload falls during WAIT, then the ack arrives -> no valid pulse, cache invalid; the next rd at 0x20 issues a new request.
- Reset mid-WAIT with the ack arriving after reset -> after RESYNC, port_req == ack_s; the next read completes normally with correct data.
- ACK_TIMEOUT_EN, TIMEOUT=16, ack never toggles -> at cycle 16 of WAIT, ioctl_din=8'hFF, valid pulses, err=1 and stays set until reset.
